ddr3_write_burst8: RTL and testbench

Write-direction counterpart of the DDR3 read-capture path: buffers one 8-beat burst of write data and mask, then drives it to the DDR pads as rise/fall pairs with a matching DQS preamble, toggle and postamble. It sits between the controller's write-data path and the pad-level DDR output registers (one rise and one fall register per bit). All logic is on the controller clock `clk`, with one clock per DQS period, giving two data beats per `clk`.

---
 rtl/ddr3_write_burst8.sv | 164 ++++++++++++++++
 tb/tb_ddr3_write_burst8.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_write_burst8.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_write_burst8
// Purpose  : Buffers one 8-beat DDR3 write burst and drives it to the pad
//            registers as rise/fall pairs with DQS preamble/toggle/postamble.
// Revision : 1.0  initial release
// ============================================================================
module ddr3_write_burst8 #(
    parameter int DW      = 16,
    parameter int MW      = 2,
    parameter int CWL_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [2:0]    wr_ptr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          start_err,
    output logic [DW-1:0] dq_rise,
    output logic [DW-1:0] dq_fall,
    output logic [MW-1:0] dm_rise,
    output logic [MW-1:0] dm_fall,
    output logic          dq_oe,
    output logic          dqs_rise,
    output logic          dqs_fall,
    output logic          dqs_oe
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_PRE   = 3'd2,
        S_BURST = 3'd3,
        S_POST  = 3'd4
    } state_t;

    localparam bit         c_HAS_WAIT  = (CWL_CYC > 0);
    localparam logic [3:0] c_WAIT_INIT = c_HAS_WAIT ? 4'(CWL_CYC - 1) : 4'd0;

    state_t        r_state;
    logic [3:0]    r_wait_cnt;
    logic [1:0]    r_bp;

    logic [DW-1:0] r_fill_data [8];
    logic [MW-1:0] r_fill_mask [8];
    logic [DW-1:0] r_shd_data  [8];
    logic [MW-1:0] r_shd_mask  [8];

    logic          w_accept;

    assign w_accept = start && (r_state == S_IDLE);

    // The shadow copy reads the fill buffer before this edge's write lands,
    // so a write colliding with start only affects the next burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_fill_data[i] <= '0;
                r_fill_mask[i] <= '1;
                r_shd_data[i]  <= '0;
                r_shd_mask[i]  <= '1;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < 8; i++) begin
                    r_shd_data[i] <= r_fill_data[i];
                    r_shd_mask[i] <= r_fill_mask[i];
                end
            end
            if (wr_en) begin
                r_fill_data[wr_ptr] <= wr_data;
                r_fill_mask[wr_ptr] <= wr_mask;
            end
        end
    end

    // Outputs are registered from the current state, so they trail the
    // state register by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_bp       <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_err  <= 1'b0;
            dq_rise    <= '0;
            dq_fall    <= '0;
            dm_rise    <= '0;
            dm_fall    <= '0;
            dq_oe      <= 1'b0;
            dqs_rise   <= 1'b0;
            dqs_fall   <= 1'b0;
            dqs_oe     <= 1'b0;
        end else begin
            start_err <= start && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_wait_cnt <= c_WAIT_INIT;
                        r_state    <= c_HAS_WAIT ? S_WAIT : S_PRE;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= S_PRE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_PRE: begin
                    r_bp    <= 2'd0;
                    r_state <= S_BURST;
                end
                S_BURST: begin
                    r_bp <= r_bp + 2'd1;
                    if (r_bp == 2'd3) begin
                        r_state <= S_POST;
                    end
                end
                S_POST:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            busy     <= (r_state != S_IDLE);
            done     <= 1'b0;
            dq_rise  <= '0;
            dq_fall  <= '0;
            dm_rise  <= '0;
            dm_fall  <= '0;
            dq_oe    <= 1'b0;
            dqs_rise <= 1'b0;
            dqs_fall <= 1'b0;
            dqs_oe   <= 1'b0;

            case (r_state)
                S_PRE: begin
                    dqs_oe <= 1'b1;
                end
                S_BURST: begin
                    dq_oe    <= 1'b1;
                    dqs_oe   <= 1'b1;
                    dqs_rise <= 1'b1;
                    dq_rise  <= r_shd_data[{r_bp, 1'b0}];
                    dq_fall  <= r_shd_data[{r_bp, 1'b1}];
                    dm_rise  <= r_shd_mask[{r_bp, 1'b0}];
                    dm_fall  <= r_shd_mask[{r_bp, 1'b1}];
                end
                S_POST: begin
                    dqs_oe <= 1'b1;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_write_burst8.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_write_burst8
// Purpose  : Scoreboard bench for ddr3_write_burst8 (CWL 2 and CWL 0 units).
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr3_write_burst8;

    typedef struct packed {
        logic [15:0] dr;
        logic [15:0] df;
        logic [1:0]  mr;
        logic [1:0]  mf;
    } beat_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  wr_en;
    logic [1:0]  start;
    logic [2:0]  wr_ptr  [2];
    logic [15:0] wr_data [2];
    logic [1:0]  wr_mask [2];

    logic [1:0]  busy, done, start_err, dq_oe, dqs_rise, dqs_fall, dqs_oe;
    logic [15:0] dq_rise [2];
    logic [15:0] dq_fall [2];
    logic [1:0]  dm_rise [2];
    logic [1:0]  dm_fall [2];

    int          checks = 0;
    int          errors = 0;
    beat_t       q0[$];
    beat_t       q1[$];
    logic [15:0] m_data [2][8];
    logic [1:0]  m_mask [2][8];

    always #5 clk = ~clk;

    ddr3_write_burst8 #(.DW(16), .MW(2), .CWL_CYC(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en[0]), .wr_ptr(wr_ptr[0]), .wr_data(wr_data[0]), .wr_mask(wr_mask[0]),
        .start(start[0]), .busy(busy[0]), .done(done[0]), .start_err(start_err[0]),
        .dq_rise(dq_rise[0]), .dq_fall(dq_fall[0]), .dm_rise(dm_rise[0]), .dm_fall(dm_fall[0]),
        .dq_oe(dq_oe[0]), .dqs_rise(dqs_rise[0]), .dqs_fall(dqs_fall[0]), .dqs_oe(dqs_oe[0])
    );

    ddr3_write_burst8 #(.DW(16), .MW(2), .CWL_CYC(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en[1]), .wr_ptr(wr_ptr[1]), .wr_data(wr_data[1]), .wr_mask(wr_mask[1]),
        .start(start[1]), .busy(busy[1]), .done(done[1]), .start_err(start_err[1]),
        .dq_rise(dq_rise[1]), .dq_fall(dq_fall[1]), .dm_rise(dm_rise[1]), .dm_fall(dm_fall[1]),
        .dq_oe(dq_oe[1]), .dqs_rise(dqs_rise[1]), .dqs_fall(dqs_fall[1]), .dqs_oe(dqs_oe[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, start_err, dq_oe, dqs_oe, dqs_rise, dqs_fall}
    function automatic logic [6:0] ctl(input int u);
        return {busy[u], done[u], start_err[u], dq_oe[u], dqs_oe[u], dqs_rise[u], dqs_fall[u]};
    endfunction

    // Expected control outputs k edges after the accepting edge E0.
    function automatic logic [6:0] exp_ctl(input int c, input int k);
        if (k == 0 || k >= c + 7) return 7'b0000000;
        if (k <= c)               return 7'b1000000;
        if (k == c + 1)           return 7'b1000100;
        if (k <= c + 5)           return 7'b1001110;
        return 7'b1100100;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 8; i++) begin
                m_data[u][i] = 16'h0000;
                m_mask[u][i] = 2'b11;
            end
    endtask

    task automatic push_pairs(input int u, input int n);
        beat_t b;
        for (int p = 0; p < n; p++) begin
            b = {m_data[u][2*p], m_data[u][2*p+1], m_mask[u][2*p], m_mask[u][2*p+1]};
            if (u == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic wr(input int u, input logic [2:0] p, input logic [15:0] d, input logic [1:0] m);
        wr_en[u] = 1'b1; wr_ptr[u] = p; wr_data[u] = d; wr_mask[u] = m;
        tick();
        wr_en[u] = 1'b0;
        m_data[u][p] = d;
        m_mask[u][p] = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // skip: E0 was already taken by a chained start; chain: start again at E(c+7).
    task automatic burst(input int u, input bit chain, input bit skip, input string tag);
        int c;
        c = (u == 0) ? 2 : 0;
        if (!skip) begin
            push_pairs(u, 4);
            start[u] = 1'b1;
            tick();
            start[u] = 1'b0;
            if (wr_en[u]) begin
                m_data[u][wr_ptr[u]] = wr_data[u];
                m_mask[u][wr_ptr[u]] = wr_mask[u];
                wr_en[u] = 1'b0;
            end
            check($sformatf("%s ctl k0", tag), 64'(ctl(u)), 64'(exp_ctl(c, 0)));
        end
        for (int k = 1; k <= c + 7; k++) begin
            if (chain && k == c + 7) begin
                push_pairs(u, 4);
                start[u] = 1'b1;
            end
            tick();
            start[u] = 1'b0;
            check($sformatf("%s ctl k%0d", tag, k), 64'(ctl(u)), 64'(exp_ctl(c, k)));
        end
    endtask

    // Monitor: every presented beat pair is popped from its unit's queue.
    always @(negedge clk) begin
        beat_t got;
        beat_t want;
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                got = {dq_rise[u], dq_fall[u], dm_rise[u], dm_fall[u]};
                if (dq_oe[u]) begin
                    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected beat u%0d: got %h expected none", u, got);
                    end else begin
                        want = (u == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("beat u%0d", u), 64'(got), 64'(want));
                    end
                end else begin
                    check($sformatf("idle dq/dm u%0d", u), 64'(got), 64'd0);
                end
            end
        end
    end

    initial begin
        wr_en = 2'b00;
        start = 2'b00;
        for (int u = 0; u < 2; u++) begin
            wr_ptr[u] = 3'd0; wr_data[u] = 16'h0; wr_mask[u] = 2'b00;
        end
        model_reset();
        reset = 1'b1;
        repeat (3) tick();
        check("reset ctl u0", 64'(ctl(0)), 64'd0);
        check("reset ctl u1", 64'(ctl(1)), 64'd0);
        check("reset dq u0", 64'({dq_rise[0], dq_fall[0], dm_rise[0], dm_fall[0]}), 64'd0);
        reset = 1'b0;

        // Basic burst
        for (int i = 0; i < 8; i++) wr(0, 3'(i), 16'h1000 + 16'(i), 2'b00);
        burst(0, 1'b0, 1'b0, "basic");

        // Snapshot collision, then resend with the new entry 3
        wr_en[0] = 1'b1; wr_ptr[0] = 3'd3; wr_data[0] = 16'hAAAA; wr_mask[0] = 2'b00;
        burst(0, 1'b0, 1'b0, "collide");
        burst(0, 1'b0, 1'b0, "resend");

        // Unwritten entries stay masked with zero data
        do_reset();
        wr(0, 3'd0, 16'h5A5A, 2'b01);
        burst(0, 1'b0, 1'b0, "masked");

        // Ignored starts during pair 1 (E6) and POST (E8)
        push_pairs(0, 4);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("ign ctl k0", 64'(ctl(0)), 64'(exp_ctl(2, 0)));
        for (int k = 1; k <= 9; k++) begin
            if (k == 6 || k == 8) start[0] = 1'b1;
            tick();
            start[0] = 1'b0;
            check($sformatf("ign ctl k%0d", k), 64'(ctl(0)),
                  64'(exp_ctl(2, k) | ((k == 6 || k == 8) ? 7'b0010000 : 7'b0000000)));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("no second burst %0d", k), 64'(ctl(0)), 64'd0);
        end

        // Mid-burst reset while pair 2 is on the pads
        push_pairs(0, 2);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("rst run ctl k%0d", k), 64'(ctl(0)), 64'(exp_ctl(2, k)));
        end
        reset = 1'b1;
        #1;
        check("mid reset ctl", 64'(ctl(0)), 64'd0);
        check("mid reset dq", 64'({dq_rise[0], dq_fall[0], dm_rise[0], dm_fall[0]}), 64'd0);
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        burst(0, 1'b0, 1'b0, "post-reset");

        // Zero write latency with a back-to-back start at E7
        for (int i = 0; i < 8; i++) wr(1, 3'(i), 16'h2000 + 16'(i), 2'(i));
        burst(1, 1'b1, 1'b0, "cwl0 first");
        burst(1, 1'b0, 1'b1, "cwl0 second");

        repeat (3) tick();
        check("leftover beats u0", 64'(q0.size()), 64'd0);
        check("leftover beats u1", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
